mux_rr_stream: RTL and testbench
================================

Name: mux_rr_stream

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer with round-robin arbitration and valid/ready handshake on every port.
- Successor to the fixed 4-to-1 combinational mux cells in the basic-cell library.
- Generalises channel count and width, and adds registered output, fair arbitration and backpressure.
- Sits between multiple producer cells and a single consumer inside the basic-cell test top.

Parameters:
- N, 4, number of input channels (2..16, non-power-of-2 allowed).
- W, 8, data width per channel (1..64).
- SEL_W, derived as max(1, clog2(N)), width of the channel-index output; not overridden by users.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset. Applies immediately on assertion; released synchronously to clk by the surrounding logic.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. in_ready=0 for as long as rst is high.
- load = !out_valid || out_ready. The output register may take a new beat in this cycle, so full throughput of 1 beat/cycle is supported.
- Arbitration is combinational when load=1.
  - grant = first channel with in_valid set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - in_ready = one-hot(grant) if load and any in_valid is set; otherwise all zero.
  - in_ready may depend combinationally on in_valid and out_ready. in_valid must not depend on in_ready.
- Transfer on input i: in_valid[i] && in_ready[i] at a clk edge. That edge performs:
  - out_data <= channel i data
  - out_sel <= i
  - out_valid <= 1
  - ptr <= (i == N-1) ? 0 : i+1, with explicit wrap (not a modulo power of 2).
- Load with no input valid: out_valid <= 0. out_data and out_sel hold their old values; they are don't-care when out_valid=0.
- No load (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr all hold. in_ready is all zero.
- Latency: a beat accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
- Simultaneous out_ready and new grant: the old beat is consumed and the new beat is loaded on the same edge, with no bubble.
- A single requester is granted every cycle regardless of ptr. No starvation: any continuously valid channel is granted within N transfers.
- Reset mid-operation: the beat in the output register is discarded, ptr returns to 0 and no in_ready is issued until rst falls.
- Internal state: output register and ptr only. No FIFO.

Optional Feature:
- Macro: MUX_RR_STREAM_LAST_EN.
- When defined:
  - Adds port in_last (input, N bits) and port out_last (output, 1 bit, reset 0, registered alongside out_data).
  - Adds a lock flag (reset 0) and a lock_ch register (reset 0).
  - A transfer with in_last=0 sets lock=1 and lock_ch=grant.
  - While lock=1, only lock_ch may be granted and ptr does not advance.
  - A transfer with in_last=1 clears lock and advances ptr as normal.
  - Result: packets from different channels are never interleaved.
- When not defined: ports and lock logic are absent, and every beat is arbitrated independently.

Test Plan:
- Reset: rst=1 with in_valid=4'hF and out_ready=1 -> in_ready=0 and out_valid=0 throughout. Deassert rst -> the first beat comes from ch0, visible one cycle later.
- N=4, all valid continuously, out_ready=1, ch i data=8'hA0+i -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data A0,A1,A2,A3,A0.
- Only ch2 valid, out_ready=1 for 5 cycles -> in_ready=4'b0100 every cycle, 5 beats out with out_sel=2, no bubbles.
- Backpressure: out_valid=1 holding ch1 data, out_ready=0 for 3 cycles with ch2 and ch3 valid -> out_data and out_sel stable, in_ready=0. Then out_ready=1 -> ch2 is granted next.
- Wrap with N=3: ch2 granted, then ch0 and ch2 both valid -> ch0 is granted and ptr becomes 1.
- With MUX_RR_STREAM_LAST_EN, N=4: ch1 sends 3 beats (last on beat 3) while ch0 stays valid -> out_sel=1,1,1 then 0; out_last=1 only on the third beat.

Source files
------------

// File: rtl/mux_rr_stream_if.sv
// mux_rr_stream_if: stream bundle for mux_rr_stream (in_last/out_last present with MUX_RR_STREAM_LAST_EN)
interface mux_rr_stream_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  logic out_ready;
`ifdef MUX_RR_STREAM_LAST_EN
  logic [N-1:0] in_last;
  logic out_last;
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_sel, out_last);
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_sel, out_last);
`else
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
`endif
endinterface

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel registered round-robin stream mux; MUX_RR_STREAM_LAST_EN adds packet locking
module mux_rr_stream #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  mux_rr_stream_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  logic [SEL_W-1:0] ptr, grant, sel_q, nxt;
  logic [SEL_W:0] idx;
  logic [N-1:0] req;
  logic [W-1:0] data_q;
  logic valid_q, found, load;
`ifdef MUX_RR_STREAM_LAST_EN
  logic lock, last_q;
  logic [SEL_W-1:0] lock_ch;
  assign req = lock ? (bus.in_valid & (N'(1) << lock_ch)) : bus.in_valid;
  assign bus.out_last = last_q;
`else
  assign req = bus.in_valid;
`endif
  assign load = !valid_q || bus.out_ready;
  assign nxt = (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_sel = sel_q;
  // first requester scanning ptr upward with explicit wrap at N
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SEL_W + 1)'(k);
      idx = (idx >= (SEL_W + 1)'(N)) ? idx - (SEL_W + 1)'(N) : idx;
      if (!found && req[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        grant = idx[SEL_W-1:0];
      end
    end
    bus.in_ready = (load && found && !rst) ? (N'(1) << grant) : '0;
  end
  // output register, rr pointer and packet lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
      ptr <= '0;
`ifdef MUX_RR_STREAM_LAST_EN
      lock <= 1'b0;
      lock_ch <= '0;
      last_q <= 1'b0;
`endif
    end else if (load) begin
      valid_q <= found;
      if (found) begin
        data_q <= bus.in_data[int'(grant)*W +: W];
        sel_q <= grant;
`ifdef MUX_RR_STREAM_LAST_EN
        last_q <= bus.in_last[grant];
        lock <= !bus.in_last[grant];
        lock_ch <= grant;
        ptr <= bus.in_last[grant] ? nxt : ptr;
`else
        ptr <= nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed self-checking bench for mux_rr_stream (N=4 and N=3 instances)
module tb_mux_rr_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  mux_rr_stream_if #(.N(4), .W(8)) b4 ();
  mux_rr_stream_if #(.N(3), .W(8)) b3 ();
  mux_rr_stream #(.N(4), .W(8)) u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_rr_stream #(.N(3), .W(8)) u3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b4.in_valid = '0;
    b3.in_valid = '0;
`ifdef MUX_RR_STREAM_LAST_EN
    b4.in_last = '1;
    b3.in_last = '1;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.in_valid = 4'hF;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", b4.in_ready); end
      checks++;
      if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", b4.out_valid); end
    end
    checks++;
    if (b4.out_sel !== 2'd0 || b4.out_data !== 8'h00) begin errors++; $display("FAIL reset_regs got sel=%0d data=%h exp sel=0 data=00", b4.out_sel, b4.out_data); end
    rst = 1'b0;
    #1;
    checks++;
    if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", b4.in_ready); end
    step();
    checks++;
    if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'd0 || b4.out_data !== 8'hA0) begin errors++; $display("FAIL reset_first_beat got v=%b sel=%0d data=%h exp v=1 sel=0 data=a0", b4.out_valid, b4.out_sel, b4.out_data); end
  endtask

  task automatic test_round_robin();
    logic [1:0] es;
    do_reset();
    b4.in_valid = 4'hF;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      es = 2'(i % 4);
      step();
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_sel !== es || b4.out_data !== 8'hA0 + 8'(es)) begin errors++; $display("FAIL rr_beat%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h", i, b4.out_valid, b4.out_sel, b4.out_data, es, 8'hA0 + 8'(es)); end
    end
  endtask

  task automatic test_single();
    do_reset();
    b4.in_valid = 4'b0100;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready%0d got=%b exp=0100", i, b4.in_ready); end
      step();
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'd2 || b4.out_data !== 8'hA2) begin errors++; $display("FAIL single_beat%0d got v=%b sel=%0d data=%h exp v=1 sel=2 data=a2", i, b4.out_valid, b4.out_sel, b4.out_data); end
    end
    b4.in_valid = 4'b0000;
    step();
    checks++;
    if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b exp=0", b4.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    b4.in_valid = 4'b0010;
    b4.out_ready = 1'b1;
    step();
    b4.in_valid = 4'b1100;
    b4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0000", i, b4.in_ready); end
      step();
      checks++;
      if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'd1 || b4.out_data !== 8'hA1) begin errors++; $display("FAIL bp_hold%0d got v=%b sel=%0d data=%h exp v=1 sel=1 data=a1", i, b4.out_valid, b4.out_sel, b4.out_data); end
    end
    b4.out_ready = 1'b1;
    #1;
    checks++;
    if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", b4.in_ready); end
    step();
    checks++;
    if (b4.out_sel !== 2'd2 || b4.out_data !== 8'hA2) begin errors++; $display("FAIL bp_release_beat got sel=%0d data=%h exp sel=2 data=a2", b4.out_sel, b4.out_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    b3.out_ready = 1'b1;
    b3.in_valid = 3'b100;
    step();
    checks++;
    if (b3.out_sel !== 2'd2 || b3.out_data !== 8'hC2) begin errors++; $display("FAIL wrap_ch2 got sel=%0d data=%h exp sel=2 data=c2", b3.out_sel, b3.out_data); end
    b3.in_valid = 3'b101;
    #1;
    checks++;
    if (b3.in_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant0 got=%b exp=001", b3.in_ready); end
    step();
    checks++;
    if (b3.out_sel !== 2'd0 || b3.out_data !== 8'hC0) begin errors++; $display("FAIL wrap_beat0 got sel=%0d data=%h exp sel=0 data=c0", b3.out_sel, b3.out_data); end
    checks++;
    if (b3.in_ready !== 3'b100) begin errors++; $display("FAIL wrap_ptr1 got=%b exp=100", b3.in_ready); end
    b3.in_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    b4.in_valid = 4'b1000;
    b4.out_ready = 1'b0;
    step();
    checks++;
    if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'd3) begin errors++; $display("FAIL mid_loaded got v=%b sel=%0d exp v=1 sel=3", b4.out_valid, b4.out_sel); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b4.out_valid !== 1'b0 || b4.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_async got v=%b ready=%b exp v=0 ready=0000", b4.out_valid, b4.in_ready); end
    b4.in_valid = 4'b1001;
    b4.out_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr0 got=%b exp=0001", b4.in_ready); end
  endtask

`ifdef MUX_RR_STREAM_LAST_EN
  task automatic test_last();
    logic [1:0] es [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    b4.out_ready = 1'b1;
    b4.in_valid = 4'b0001;
    b4.in_last = 4'b1111;
    step();
    b4.in_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      b4.in_last = (i == 2) ? 4'b0011 : 4'b0001;
      step();
      checks++;
      if (b4.out_sel !== es[i] || b4.out_last !== el[i]) begin errors++; $display("FAIL last_beat%0d got sel=%0d last=%b exp sel=%0d last=%b", i, b4.out_sel, b4.out_last, es[i], el[i]); end
    end
  endtask
`endif

  initial begin
    b4.in_valid = '0;
    b4.out_ready = 1'b0;
    b4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b3.in_valid = '0;
    b3.out_ready = 1'b0;
    b3.in_data = {8'hC2, 8'hC1, 8'hC0};
`ifdef MUX_RR_STREAM_LAST_EN
    b4.in_last = '1;
    b3.in_last = '1;
`endif
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef MUX_RR_STREAM_LAST_EN
    test_last();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
